// File: rtl/register_file_sync_if.sv
// Bundled decode/writeback bus of the MUSA register file: read ports, write port,
// clear request and busy status.
interface register_file_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  clear;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] rs_addr;
    logic [ADDR_WIDTH-1:0] rt_addr;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_1;
    logic [DATA_WIDTH-1:0] data_2;
    logic                  data_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output clear, rs_addr, rt_addr, read_en, rd_addr, write_en, write_data,
        input  busy, data_1, data_2, data_valid
    );

    modport slave (
        input  clear, rs_addr, rt_addr, read_en, rd_addr, write_en, write_data,
        output busy, data_1, data_2, data_valid
    );
endinterface

// File: rtl/register_file_sync.sv
// Clocked MUSA register file: one write port, two registered read ports, optional zero
// register and a clear sweep. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
module register_file_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    register_file_sync_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH:0]   ptr, next_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  wr_accept;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_val_1, rd_val_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // The sweep owns the write port while in CLEAR; a clear request restarts it from entry 0.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        mem_we     = 1'b0;
        mem_waddr  = bus.rd_addr;
        mem_wdata  = bus.write_data;
        wr_accept  = 1'b0;
        rd_fire    = 1'b0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr[ADDR_WIDTH-1:0];
                mem_wdata = '0;
                if (bus.clear) begin
                    next_ptr = '0;
                end else if (ptr == PTR_LAST) begin
                    next_state = IDLE;
                    next_ptr   = '0;
                end else begin
                    next_ptr = ptr + PTR_ONE;
                end
            end
            IDLE: begin
                rd_fire   = bus.read_en;
                wr_accept = bus.write_en && !bus.clear &&
                            !((ZERO_REG != 0) && (bus.rd_addr == '0));
                mem_we    = wr_accept;
                if (bus.clear) begin
                    next_state = CLEAR;
                    next_ptr   = '0;
                end
            end
            default: begin
                next_state = CLEAR;
                next_ptr   = '0;
            end
        endcase
    end

    assign bus.busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Address 0 reads as zero with the zero register enabled; forwarding only follows accepted writes.
    always_comb begin
        rd_val_1 = mem[bus.rs_addr];
        rd_val_2 = mem[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (bus.rs_addr == bus.rd_addr)) rd_val_1 = bus.write_data;
        if (wr_accept && (bus.rt_addr == bus.rd_addr)) rd_val_2 = bus.write_data;
`endif
        if ((ZERO_REG != 0) && (bus.rs_addr == '0)) rd_val_1 = '0;
        if ((ZERO_REG != 0) && (bus.rt_addr == '0)) rd_val_2 = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_1     <= '0;
            bus.data_2     <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= rd_fire;
            if (rd_fire) begin
                bus.data_1 <= rd_val_1;
                bus.data_2 <= rd_val_2;
            end
        end
    end
endmodule

// File: doc/register_file_sync.md
Name: register_file_sync

Overview:
Clocked, parametrised general-purpose register file for the MUSA core. It is the successor to the combinational-event register bank.
- Synchronous write port.
- Two registered read ports with a valid strobe.
- Optional hardwired zero register.
- Hardware clear sequencer that sweeps every entry to zero after reset or on request.
- Sits between decode (RS/RT read) and writeback (RD write).

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, address bits; depth DEPTH = 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes; when 0 entry 0 is ordinary storage.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  single-cycle request to zero all entries.
- busy  output  1  high while the clear sweep runs.
- rs_addr  input  ADDR_WIDTH  read address, port 1.
- rt_addr  input  ADDR_WIDTH  read address, port 2.
- read_en  input  1  capture both read ports this edge.
- data_1  output  DATA_WIDTH  registered read data, port 1.
- data_2  output  DATA_WIDTH  registered read data, port 2.
- data_valid  output  1  one-cycle strobe: data_1/data_2 updated on the previous edge.
- rd_addr  input  ADDR_WIDTH  write address.
- write_en  input  1  write strobe.
- write_data  input  DATA_WIDTH  write data.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (while rst_n=0):
  - data_1 = 0, data_2 = 0, data_valid = 0.
  - busy = 1, state = CLEAR, sweep pointer ptr = 0.
  - Storage array is not reset directly.
- FSM has two states, CLEAR and IDLE.
  - CLEAR: each edge writes 0 to mem[ptr] and increments ptr. The edge that writes mem[DEPTH-1] moves the FSM to IDLE. busy falls with that edge.
  - Sweep length after rst_n release is exactly DEPTH edges (32 at defaults).
  - IDLE: clear=1 at an edge moves to CLEAR with ptr=0 and busy=1.
  - clear=1 while already in CLEAR restarts the sweep at ptr=0.
- During CLEAR:
  - write_en and read_en are ignored.
  - data_1/data_2 hold their values and data_valid=0.
- Write (IDLE, write_en=1): mem[rd_addr] <= write_data at the edge.
  - With ZERO_REG=1 and rd_addr=0, the write is dropped.
  - clear=1 and write_en=1 on the same IDLE edge: clear wins, write dropped.
- Read (IDLE, read_en=1): at edge N, data_1 <= mem[rs_addr] and data_2 <= mem[rt_addr]. data_valid=1 for the cycle after edge N.
  - Latency is 1 edge.
  - With read_en=0, outputs hold and data_valid=0 next cycle.
  - With ZERO_REG=1, address 0 reads 0 regardless of storage.
- Same-edge read and write to the same address, feature disabled: the read returns the pre-write (old) value.
- rs_addr == rt_addr is legal; both ports return the same value.
- Reset asserted mid-sweep or mid-read: outputs go immediately to reset values and the sweep restarts from ptr=0 on release.
- Width rules: addresses are never out of range (full 2**ADDR_WIDTH decode). ptr is ADDR_WIDTH+1 bits or saturates, so it never wraps before the FSM exits CLEAR.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined:
  - Same-edge read and write_en (write accepted) with rs_addr==rd_addr loads data_1 with write_data. rt_addr==rd_addr loads data_2 likewise. The new value is visible with 1-edge latency.
  - Bypass is suppressed when ZERO_REG=1 and rd_addr=0; that port still returns 0.
  - Bypass is suppressed when the write is dropped by clear.
- When undefined: the read returns the old value, as above; no forwarding muxes.

Test Plan:
- Release rst_n, hold clear=0 -> busy=1 for exactly 32 edges, then 0. Read all 32 addresses -> every data_1/data_2 = 0x00000000, data_valid pulses once per read.
- IDLE: write 0xDEADBEEF to r5, next cycle read rs=5, rt=5 -> data_1 = data_2 = 0xDEADBEEF, data_valid=1 one cycle after the read edge.
- ZERO_REG=1: write 0x12345678 to r0, then read rs=0 -> data_1=0. ZERO_REG=0: same sequence -> data_1=0x12345678.
- r7=0x1, same edge write_en r7=0x2 with read rs=7 -> data_1=0x1 without REGFILE_BYPASS_EN, 0x2 with it. Following read -> 0x2 in both builds.
- Fill r1..r3 with 0xA, 0xB, 0xC. Pulse clear together with write_en r4=0xD -> busy for 32 edges, read/write ignored during the sweep. Afterward r1..r4 all read 0; data_valid stays 0 during the sweep.
- Assert rst_n=0 at sweep edge 10 with data_1 holding 0xFFFF -> data_1=0 and data_valid=0 immediately. On release, busy stays high a full 32 edges.
